// File: rtl/crypt_pkg.sv
// Shared types and derivations for the crypt_pipeline block cipher datapath.
// Mode encoding, round-key width and pipeline depth live here so every file agrees.
package crypt_pkg;

   typedef enum logic {
      MODE_ENC = 1'b0,
      MODE_DEC = 1'b1
   } mode_e;

   // Rotation amounts used by the round function on each quarter word.
   localparam int ROT_A = 3;
   localparam int ROT_B = 5;

   function automatic int key_width(input int block_size);
      return block_size * 3 / 4;
   endfunction

   function automatic int stage_count(input int round_num, input int rps);
      return round_num / rps;
   endfunction

endpackage

// File: rtl/crypt_round.sv
// Forward cipher round: word-rotating ARX Feistel over four quarter words.
// The block word w0 passes through and keys the update of the other three words.
module crypt_round
   import crypt_pkg::*;
#(
   parameter int BLOCK_SIZE = 64
) (
   input  logic [BLOCK_SIZE-1:0]            din,
   input  logic [key_width(BLOCK_SIZE)-1:0] key,
   output logic [BLOCK_SIZE-1:0]            dout
);

   localparam int Q = BLOCK_SIZE / 4;

   function automatic logic [Q-1:0] rotl(input logic [Q-1:0] x, input int r);
      logic [2*Q-1:0] d;
      d = {x, x} << (r % Q);
      return d[2*Q-1:Q];
   endfunction

   logic [Q-1:0] w0, w1, w2, w3;
   logic [Q-1:0] k0, k1, k2;

   assign {w3, w2, w1, w0} = din;
   assign {k2, k1, k0}     = key;

   assign dout = {w0,
                  w3 + rotl(w0 ^ k2, ROT_B),
                  w2 ^ (w0 + k1),
                  w1 + (rotl(w0, ROT_A) ^ k0)};

endmodule

// File: rtl/crypt_stage.sv
// One pipeline stage of combinational rounds: RPS forward rounds and RPS inverse
// rounds computed side by side, the result selected by the block's mode.
module crypt_stage
   import crypt_pkg::*;
#(
   parameter int BLOCK_SIZE = 64,
   parameter int RPS        = 1
) (
   input  logic [BLOCK_SIZE-1:0]                      data,
   input  mode_e                                      mode,
   input  logic [RPS-1:0][key_width(BLOCK_SIZE)-1:0]  enc_keys,
   input  logic [RPS-1:0][key_width(BLOCK_SIZE)-1:0]  dec_keys,
   output logic [BLOCK_SIZE-1:0]                      result
);

   localparam int Q  = BLOCK_SIZE / 4;
   localparam int KW = key_width(BLOCK_SIZE);

   function automatic logic [Q-1:0] rotl(input logic [Q-1:0] x, input int r);
      logic [2*Q-1:0] d;
      d = {x, x} << (r % Q);
      return d[2*Q-1:Q];
   endfunction

   // Undoes crypt_round: the top word is the untouched w0, which keys the rest.
   function automatic logic [BLOCK_SIZE-1:0] inv_round(input logic [BLOCK_SIZE-1:0] y,
                                                      input logic [KW-1:0]         key);
      logic [Q-1:0] w0, k0, k1, k2;
      w0           = y[4*Q-1 -: Q];
      {k2, k1, k0} = key;
      return {y[3*Q-1 -: Q] - rotl(w0 ^ k2, ROT_B),
              y[2*Q-1 -: Q] ^ (w0 + k1),
              y[Q-1:0] - (rotl(w0, ROT_A) ^ k0),
              w0};
   endfunction

   for (genvar i = 0; i < RPS; i++) begin : g_rnd
      logic [BLOCK_SIZE-1:0] f_in, f_out, i_in, i_out;

      if (i == 0) begin : g_first
         assign f_in = data;
         assign i_in = data;
      end else begin : g_next
         assign f_in = g_rnd[i-1].f_out;
         assign i_in = g_rnd[i-1].i_out;
      end

      crypt_round #(.BLOCK_SIZE(BLOCK_SIZE)) u_round (
         .din  (f_in),
         .key  (enc_keys[i]),
         .dout (f_out)
      );

      assign i_out = inv_round(i_in, dec_keys[i]);
   end

   assign result = (mode == MODE_DEC) ? g_rnd[RPS-1].i_out : g_rnd[RPS-1].f_out;

endmodule

// File: rtl/crypt_pipeline.sv
// Elastic block-cipher pipeline: STAGES register stages, each followed by RPS rounds,
// with per-stage backpressure so a full pipe still accepts and drains in one cycle.
module crypt_pipeline
   import crypt_pkg::*;
#(
   parameter int ROUND_NUM  = 32,
   parameter int BLOCK_SIZE = 64,
   parameter int RPS        = 1,
   parameter int ID_W       = 4
) (
   input  logic                                            clk,
   input  logic                                            rst,
   input  logic [ROUND_NUM-1:0][key_width(BLOCK_SIZE)-1:0] round_keys,
   input  logic [BLOCK_SIZE-1:0]                           s_axis_tdata,
   input  logic                                            s_axis_tuser,
   input  logic [ID_W-1:0]                                 s_axis_tid,
   input  logic                                            s_axis_tvalid,
   output logic                                            s_axis_tready,
   output logic [BLOCK_SIZE-1:0]                           m_axis_tdata,
   output logic                                            m_axis_tuser,
   output logic [ID_W-1:0]                                 m_axis_tid,
   output logic                                            m_axis_tvalid,
   input  logic                                            m_axis_tready,
   output logic [$clog2(stage_count(ROUND_NUM, RPS)+1)-1:0] occupancy,
   output logic                                            busy
);

   localparam int KW     = key_width(BLOCK_SIZE);
   localparam int STAGES = stage_count(ROUND_NUM, RPS);
   localparam int OW     = $clog2(STAGES + 1);

   if ((ROUND_NUM % RPS) != 0 || (BLOCK_SIZE % 4) != 0) begin : g_bad_param
      $error("crypt_pipeline: ROUND_NUM must be a multiple of RPS and BLOCK_SIZE a multiple of 4");
   end

   logic [STAGES-1:0]     valid_q;
   logic [STAGES-1:0]     adv;
   logic [BLOCK_SIZE-1:0] data_q    [STAGES];
   mode_e                 mode_q    [STAGES];
   logic [ID_W-1:0]       tag_q     [STAGES];
   logic [BLOCK_SIZE-1:0] stage_out [STAGES];
   logic                  accept, drain;

   // A stage may load when it is empty or its contents move on; this ripples back
   // from the output so a full pipe still streams one block per cycle.
   always_comb begin
      // NOTE: every bit gets a default first so no path leaves adv unassigned (no latch).
      adv           = '0;
      adv[STAGES-1] = !valid_q[STAGES-1] || m_axis_tready;
      for (int k = STAGES - 2; k >= 0; k--) begin
         adv[k] = !valid_q[k] || adv[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [RPS-1:0][KW-1:0] enc_keys, dec_keys;

      // Decryption walks the key schedule backwards from the last round key.
      for (genvar i = 0; i < RPS; i++) begin : g_key
         assign enc_keys[i] = round_keys[k*RPS + i];
         assign dec_keys[i] = round_keys[ROUND_NUM - 1 - (k*RPS + i)];
      end

      crypt_stage #(
         .BLOCK_SIZE (BLOCK_SIZE),
         .RPS        (RPS)
      ) u_stage (
         .data     (data_q[k]),
         .mode     (mode_q[k]),
         .enc_keys (enc_keys),
         .dec_keys (dec_keys),
         .result   (stage_out[k])
      );
   end

   assign accept = s_axis_tvalid && s_axis_tready;
   assign drain  = m_axis_tvalid && m_axis_tready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: payload registers are cleared too, not just valid bits, so nothing
         // from before reset is ever observable on the outputs.
         valid_q   <= '0;
         occupancy <= '0;
         for (int k = 0; k < STAGES; k++) begin
            data_q[k] <= '0;
            mode_q[k] <= MODE_ENC;
            tag_q[k]  <= '0;
         end
      end else begin
         // NOTE: non-blocking updates let stage k read stage k-1's old value this edge.
         if (adv[0]) begin
            valid_q[0] <= s_axis_tvalid;
            data_q[0]  <= s_axis_tdata;
            mode_q[0]  <= mode_e'(s_axis_tuser);
            tag_q[0]   <= s_axis_tid;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (adv[k]) begin
               valid_q[k] <= valid_q[k-1];
               data_q[k]  <= stage_out[k-1];
               mode_q[k]  <= mode_q[k-1];
               tag_q[k]   <= tag_q[k-1];
            end
         end
         unique case ({accept, drain})
            2'b10:   occupancy <= occupancy + OW'(1);
            2'b01:   occupancy <= occupancy - OW'(1);
            default: ;
         endcase
      end
   end

   assign s_axis_tready = adv[0];
   assign m_axis_tvalid = valid_q[STAGES-1];
   assign m_axis_tdata  = stage_out[STAGES-1];
   assign m_axis_tuser  = mode_q[STAGES-1];
   assign m_axis_tid    = tag_q[STAGES-1];
   assign busy          = (occupancy != '0);

endmodule

// File: doc/crypt_pipeline.md
CRYPT_PIPELINE -- requirements
Module: crypt_pipeline

Interface
REQ-001 SHALL have parameter ROUND_NUM, default 32: total cipher rounds.
REQ-002 SHALL have parameter BLOCK_SIZE, default 64: data block width in bits; round key width is BLOCK_SIZE*3/4.
REQ-003 SHALL have parameter RPS, default 1: rounds per pipeline stage; STAGES = ROUND_NUM/RPS.
REQ-004 SHALL have parameter ID_W, default 4: width of the per-transaction tag.
REQ-005 SHALL have port clk, input, 1: the single clock; all registers sample on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port round_keys, input, ROUND_NUM x BLOCK_SIZE*3/4: round keys in encryption order, held static while busy is high.
REQ-008 SHALL have port s_axis_tdata, input, BLOCK_SIZE: input block.
REQ-009 SHALL have port s_axis_tuser, input, 1: mode; 0 = encrypt, 1 = decrypt.
REQ-010 SHALL have port s_axis_tid, input, ID_W: transaction tag.
REQ-011 SHALL have port s_axis_tvalid, input, 1 and port s_axis_tready, output, 1: input handshake.
REQ-012 SHALL have port m_axis_tdata, output, BLOCK_SIZE: result block.
REQ-013 SHALL have port m_axis_tuser, output, 1: mode of the result.
REQ-014 SHALL have port m_axis_tid, output, ID_W: tag of the result.
REQ-015 SHALL have port m_axis_tvalid, output, 1 and port m_axis_tready, input, 1: output handshake.
REQ-016 SHALL have port occupancy, output, clog2(STAGES+1): number of valid stages.
REQ-017 SHALL have port busy, output, 1: high when occupancy is nonzero.

Function
REQ-018 SHALL elaborate only if ROUND_NUM mod RPS == 0 and BLOCK_SIZE mod 4 == 0; otherwise $error.
REQ-019 SHALL hold per stage k (0..STAGES-1) a valid bit, data, mode and tag register.
REQ-020 SHALL advance stage k when it is empty or stage k+1 advances; the last stage advances when it is empty or m_axis_tready is high.
REQ-021 SHALL drive s_axis_tready = advance of stage 0, giving full throughput of one block per cycle under continuous m_axis_tready.
REQ-022 SHALL apply, in stage k, rounds k*RPS .. k*RPS+RPS-1 combinationally to the registered data before the next register.
REQ-023 SHALL, in encrypt mode, apply the forward round with round_keys[j] at global round j.
REQ-024 SHALL, in decrypt mode, apply the inverse round with round_keys[ROUND_NUM-1-j] at global round j, so that decrypt(encrypt(x)) = x.
REQ-025 SHALL carry mode and tag unchanged alongside the data, so mixed encrypt/decrypt traffic is allowed back-to-back.
REQ-026 SHALL have a latency from an accepted input beat to m_axis_tvalid of exactly STAGES cycles when unstalled.
REQ-027 SHALL drive m_axis_tdata from the output of the last stage's round logic; m_axis_tvalid is the last stage's valid bit.
REQ-028 SHALL hold m_axis_tdata/tuser/tid stable while m_axis_tvalid is high and m_axis_tready is low.
REQ-029 SHALL allow, when full with m_axis_tready high, a simultaneous input accept and output drain in the same cycle.
REQ-030 SHALL update occupancy as +1 on accept only, -1 on drain only, and unchanged on both or neither; it saturates at no bound because the handshake prevents overflow.
REQ-031 SHALL require that, with m_axis_tready low, the pipeline fills to STAGES entries and then s_axis_tready goes low; no beat is lost or duplicated.

Reset
REQ-032 SHALL, when rst is low, clear asynchronously every valid bit, data, mode and tag register, and occupancy, to 0.
REQ-033 SHALL give, during reset, m_axis_tvalid = 0, busy = 0, and s_axis_tready = 1.
REQ-034 SHALL discard, on reset asserted mid-operation, all in-flight blocks; none appears after release.

Structure
REQ-035 SHALL take round-key width, mode encoding (MODE_ENC/MODE_DEC) and the STAGES derivation from shared package crypt_pkg.
REQ-036 SHALL have one sub-module, crypt_stage: RPS chained rounds, forward and inverse, muxed by mode; it instantiates the existing round cell for the forward path.

Verification
REQ-037 SHALL check latency: single encrypt beat, m_axis_tready = 1 -> m_axis_tvalid exactly STAGES cycles later (32 with defaults, 8 with RPS = 4).
REQ-038 SHALL check round trip: encrypt 0x0123456789ABCDEF with tid = 3, then feed the result back as decrypt -> output 0x0123456789ABCDEF with tid = 3.
REQ-039 SHALL check mixed traffic: alternating enc/dec beats on 100 random blocks -> each output matches the golden model per mode, in order, with tags preserved.
REQ-040 SHALL check backpressure: m_axis_tready = 0 with 40 offered beats -> exactly 32 accepted, occupancy = 32, s_axis_tready = 0; on release, 32 outputs then the rest, none lost.
REQ-041 SHALL check random stalls: random tvalid and tready at 50% over 1000 beats -> output count equals input count, data stable under stall.
REQ-042 SHALL check reset mid-flight: rst low with 10 beats in flight -> m_axis_tvalid = 0 and occupancy = 0 immediately; no stale output after release.
